mul_operand_sequencer: RTL
==========================

// Module: mul_operand_sequencer
// PURPOSE
//  Parametrised, handshaked operand splitter for the vALU multiplier array. It breaks two DATA_WIDTH
//  vector operands into 16-bit chunk pairs, sign/zero-extended to MUL_WIDTH, per SEW and signedness.
//  SEW64 products are sequenced over two beats.
//  Sits between the vALU issue stage and the 18x18 multiplier array.
// PARAMETERS
//  DATA_WIDTH    64  operand width; 32 or 64
//  MUL_WIDTH     18  multiplier input width (16 data + 2 extension bits)
//  TAG_WIDTH     4   opaque tag passed from input to every output beat
//  ENABLE_64_BIT 1   SEW64 support; legal only with DATA_WIDTH=64
//  NUM_PAIRS     DATA_WIDTH/8 (derived, localparam) operand pairs per beat
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     reset, synchronous, active-high
//  in_valid   in   1                     operand bundle valid
//  in_ready   out  1                     bundle accepted when in_valid & in_ready
//  vec0       in   DATA_WIDTH            operand A
//  vec1       in   DATA_WIDTH            operand B
//  sew        in   2                     00=8, 01=16, 10=32, 11=64
//  op_sel     in   2                     00 uu, 10 su (A signed), 01/11 ss
//  in_tag     in   TAG_WIDTH             request tag
//  out_valid  out  1                     beat valid
//  out_ready  in   1                     downstream accepts beat
//  out_a      out  NUM_PAIRS*MUL_WIDTH   pair p A operand at [p*MUL_WIDTH +: MUL_WIDTH]
//  out_b      out  NUM_PAIRS*MUL_WIDTH   pair p B operand, same packing
//  out_beat   out  1                     beat index (0/1)
//  out_last   out  1                     final beat of this bundle
//  out_sew    out  2                     SEW of this beat
//  out_tag    out  TAG_WIDTH             tag of this beat
//  out_err    out  1                     illegal SEW; operands are zero
// BEHAVIOUR
//  - Reset: all outputs 0; in_ready is 1 one cycle after rst deasserts. FSM returns to IDLE; the bundle
//    in flight is dropped and no beat is emitted for it.
//  - FSM IDLE -> BEAT0 on accept. Then BEAT0 -> IDLE when the beat is taken and out_last=1.
//    BEAT0 -> BEAT1 when the beat is taken and SEW64. BEAT1 -> IDLE when the beat is taken.
//  - Latency: out_valid rises the cycle after acceptance. The BEAT1 output register loads in the same
//    cycle BEAT0 is taken.
//  - Stall: while out_valid & ~out_ready, every out_* holds stable.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last). Back-to-back single-beat bundles
//    therefore sustain one bundle per cycle.
//  - A signed = op_sel!=00; B signed = op_sel[0]. Ext bits = signed & element MSB, applied only to the
//    top chunk of each element. Every other chunk is zero-extended.
//  - SEW8: pair p = bytes p of A and B, ext to MUL_WIDTH. One beat.
//  - SEW16: pairs 0..NUM_PAIRS/2-1 = halfword p. Remaining pairs are 0. One beat.
//  - SEW32: element e, pair e*4+2i+j = A chunk i x B chunk j (i,j in 0..1). One beat.
//  - SEW64: beat k, pair p = A chunk (p>>1) x B chunk (2k+(p&1)). Two beats.
//  - SEW=11 with ENABLE_64_BIT=0: one beat, out_err=1, out_a=out_b=0, out_last=1.
//  - Unused pair lanes always drive 0 (no stale data).
// STRUCTURE
//  - Shared vALU package: SEW_8/16/32/64 codes, OPSEL_* codes, FSM state enum.
//  - Sub-module mul_chunk_ext: chunk select + conditional sign/zero extension, one instance per pair
//    per operand.
//  - Top level: input capture register, FSM, output register.
// TESTING
//  1. SEW8 ss: vec0=0x80..., vec1=0x02 in byte0 -> pair0 a=0x3FF80, b=0x00002; one beat, last=1.
//  2. SEW16 uu: A halfword0=0xFFFF -> pair0 a=0x0FFFF; pairs 4..7=0.
//  3. SEW32 su: A=0x8000_0001, B=0xFFFF_FFFF ->
//     pair0 a=0x00001, b=0x0FFFF; pair2 a=0x38000; pair1 b=0x0FFFF (unsigned, no ext).
//  4. SEW64 ss, out_ready low 3 cycles -> BEAT0 held stable; then two beats (beat 0/1);
//     last only on beat 1; in_ready low until beat 1 is taken.
//  5. Back-to-back SEW8 bundles tags 1,2,3 with out_ready=1 -> one beat per cycle, tags in order.
//  6. rst asserted between BEAT0 and BEAT1 -> outputs 0; no BEAT1 emitted; a new bundle is accepted
//    normally afterwards.
//  ENABLE_64_BIT=0 build: sew=11 -> single beat with out_err=1 and zero operands.

Source files
------------

// File: rtl/mul_operand_sequencer_pkg.sv
// Shared vALU definitions: SEW and operand-signedness codes plus the sequencer state encoding.
package mul_operand_sequencer_pkg;
   localparam logic [1:0] SEW_8  = 2'b00;
   localparam logic [1:0] SEW_16 = 2'b01;
   localparam logic [1:0] SEW_32 = 2'b10;
   localparam logic [1:0] SEW_64 = 2'b11;

   localparam logic [1:0] OPSEL_UU     = 2'b00;
   localparam logic [1:0] OPSEL_SS     = 2'b01;
   localparam logic [1:0] OPSEL_SU     = 2'b10;
   localparam logic [1:0] OPSEL_SS_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } seq_state_e;
endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Issue-side bundle and multiplier-side beat handshakes of the operand sequencer.
interface mul_operand_sequencer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int MUL_WIDTH  = 18,
   parameter int TAG_WIDTH  = 4
);
   localparam int NUM_PAIRS = DATA_WIDTH / 8;

   logic                           in_valid;
   logic                           in_ready;
   logic [DATA_WIDTH-1:0]          vec0;
   logic [DATA_WIDTH-1:0]          vec1;
   logic [1:0]                     sew;
   logic [1:0]                     op_sel;
   logic [TAG_WIDTH-1:0]           in_tag;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_PAIRS*MUL_WIDTH-1:0] out_a;
   logic [NUM_PAIRS*MUL_WIDTH-1:0] out_b;
   logic                           out_beat;
   logic                           out_last;
   logic [1:0]                     out_sew;
   logic [TAG_WIDTH-1:0]           out_tag;
   logic                           out_err;

   modport slave (
      input  in_valid, vec0, vec1, sew, op_sel, in_tag, out_ready,
      output in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_tag, out_err
   );

   modport master (
      output in_valid, vec0, vec1, sew, op_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_tag, out_err
   );
endinterface

// File: rtl/mul_chunk_ext.sv
// Picks a byte or halfword out of an operand and sign/zero-extends it to the multiplier width.
module mul_chunk_ext #(
   parameter int DATA_WIDTH = 64,
   parameter int MUL_WIDTH  = 18,
   parameter int LO_W       = 6
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [LO_W-1:0]       lo,
   input  logic                  byte_mode,
   input  logic                  sign_en,
   input  logic                  en,
   output logic [MUL_WIDTH-1:0]  ext
);
   logic [DATA_WIDTH+15:0] padded;
   logic [LO_W:0]          idx;
   logic [15:0]            chunk;
   logic                   fill;

   always_comb begin
      padded = {16'b0, data};
      idx    = {1'b0, lo};
      chunk  = padded[idx +: 16];
      fill   = sign_en & (byte_mode ? chunk[7] : chunk[15]);
      if (!en)
         ext = '0;
      else if (byte_mode)
         ext = {{(MUL_WIDTH-8){fill}}, chunk[7:0]};
      else
         ext = {{(MUL_WIDTH-16){fill}}, chunk};
   end
endmodule

// File: rtl/mul_operand_sequencer.sv
// Splits two vector operands into extended 16-bit chunk pairs for the 18x18 multiplier array;
// SEW64 bundles are emitted as two beats.
module mul_operand_sequencer #(
   parameter int DATA_WIDTH    = 64,
   parameter int MUL_WIDTH     = 18,
   parameter int TAG_WIDTH     = 4,
   parameter bit ENABLE_64_BIT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   mul_operand_sequencer_if.slave   bus
);
   import mul_operand_sequencer_pkg::*;

   localparam int NUM_PAIRS = DATA_WIDTH / 8;
   localparam int LO_W      = $clog2(DATA_WIDTH);
   localparam bit SEW64_OK  = ENABLE_64_BIT && (DATA_WIDTH == 64);

   seq_state_e state, state_nxt;
   logic       rdy_en;
   logic       out_valid_c, in_ready_c, take, accept, load_beat1;

   logic [DATA_WIDTH-1:0] vec0_p0, vec1_p0;
   logic [1:0]            sew_p0, op_p0;
   logic [TAG_WIDTH-1:0]  tag_p0;

   logic [NUM_PAIRS*MUL_WIDTH-1:0] a_p1, b_p1, a_nxt, b_nxt;
   logic                           beat_p1, last_p1, err_p1;
   logic [1:0]                     sew_p1;
   logic [TAG_WIDTH-1:0]           tag_p1;

   logic [DATA_WIDTH-1:0] src_v0, src_v1;
   logic [1:0]            src_sew, src_op;
   logic [TAG_WIDTH-1:0]  src_tag;
   logic                  src_beat, src_last, src_err, a_signed, b_signed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_BEAT0;
         ST_BEAT0: if (take) state_nxt = !last_p1 ? ST_BEAT1 : (accept ? ST_BEAT0 : ST_IDLE);
         ST_BEAT1: if (take) state_nxt = accept ? ST_BEAT0 : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid_c = (state != ST_IDLE);
      take        = out_valid_c & bus.out_ready;
      in_ready_c  = rdy_en & ((state == ST_IDLE) | (take & last_p1));
      accept      = bus.in_valid & in_ready_c;
      load_beat1  = (state == ST_BEAT0) & take & ~last_p1;
   end

   // Beat 0 is built straight from the issue bus; beat 1 from the captured bundle.
   always_comb begin
      src_v0   = accept ? bus.vec0   : vec0_p0;
      src_v1   = accept ? bus.vec1   : vec1_p0;
      src_sew  = accept ? bus.sew    : sew_p0;
      src_op   = accept ? bus.op_sel : op_p0;
      src_tag  = accept ? bus.in_tag : tag_p0;
      src_beat = ~accept;
      src_err  = (src_sew == SEW_64) & ~SEW64_OK;
      src_last = src_beat | ~((src_sew == SEW_64) & SEW64_OK);
      a_signed = (src_op != OPSEL_UU);
      b_signed = src_op[0];
   end

   for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
      localparam int CI    = (p >> 1) & 1;
      localparam int CJ    = p & 1;
      localparam int LO8   = 8 * p;
      localparam int LO16  = (16 * p) % DATA_WIDTH;
      localparam int LO32A = 32 * (p / 4) + 16 * CI;
      localparam int LO32B = 32 * (p / 4) + 16 * CJ;
      localparam int LO64A = (16 * (p >> 1)) % DATA_WIDTH;
      localparam int LO64B = 16 * CJ;

      logic [LO_W-1:0] lo_a, lo_b;
      logic            byte_m, top_a, top_b, en;

      always_comb begin
         lo_a   = LO_W'(LO8);
         lo_b   = LO_W'(LO8);
         byte_m = 1'b1;
         top_a  = 1'b1;
         top_b  = 1'b1;
         en     = 1'b1;
         case (src_sew)
            SEW_16: begin
               lo_a   = LO_W'(LO16);
               lo_b   = LO_W'(LO16);
               byte_m = 1'b0;
               en     = (p < NUM_PAIRS / 2);
            end
            SEW_32: begin
               lo_a   = LO_W'(LO32A);
               lo_b   = LO_W'(LO32B);
               byte_m = 1'b0;
               top_a  = (CI == 1);
               top_b  = (CJ == 1);
            end
            SEW_64: begin
               lo_a   = LO_W'(LO64A);
               lo_b   = LO_W'(LO64B) + (src_beat ? LO_W'(32) : '0);
               byte_m = 1'b0;
               top_a  = ((p >> 1) == 3);
               top_b  = src_beat & (CJ == 1);
               en     = SEW64_OK;
            end
            default: ;
         endcase
      end

      mul_chunk_ext #(.DATA_WIDTH(DATA_WIDTH), .MUL_WIDTH(MUL_WIDTH), .LO_W(LO_W)) u_ext_a (
         .data(src_v0), .lo(lo_a), .byte_mode(byte_m), .sign_en(a_signed & top_a), .en(en),
         .ext(a_nxt[p*MUL_WIDTH +: MUL_WIDTH])
      );
      mul_chunk_ext #(.DATA_WIDTH(DATA_WIDTH), .MUL_WIDTH(MUL_WIDTH), .LO_W(LO_W)) u_ext_b (
         .data(src_v1), .lo(lo_b), .byte_mode(byte_m), .sign_en(b_signed & top_b), .en(en),
         .ext(b_nxt[p*MUL_WIDTH +: MUL_WIDTH])
      );
   end

   // Stage p0: bundle capture, kept for the second SEW64 beat.
   always_ff @(posedge clk) begin
      if (accept) begin
         vec0_p0 <= bus.vec0;
         vec1_p0 <= bus.vec1;
         sew_p0  <= bus.sew;
         op_p0   <= bus.op_sel;
         tag_p0  <= bus.in_tag;
      end
   end

   // Stage p1: output beat register.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_p1    <= '0;
         b_p1    <= '0;
         beat_p1 <= 1'b0;
         last_p1 <= 1'b0;
         err_p1  <= 1'b0;
         sew_p1  <= '0;
         tag_p1  <= '0;
      end else if (accept | load_beat1) begin
         a_p1    <= a_nxt;
         b_p1    <= b_nxt;
         beat_p1 <= src_beat;
         last_p1 <= src_last;
         err_p1  <= src_err;
         sew_p1  <= src_sew;
         tag_p1  <= src_tag;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_a     = a_p1;
   assign bus.out_b     = b_p1;
   assign bus.out_beat  = beat_p1;
   assign bus.out_last  = last_p1;
   assign bus.out_sew   = sew_p1;
   assign bus.out_tag   = tag_p1;
   assign bus.out_err   = err_p1;
endmodule
